// File: rtl/logic_op_arbiter.sv
// Round-robin time-sharing of one NOT/AND/OR/XOR unit between NREQ requesters.
// Latency: accept edge T, EXEC during T+1, rsp_valid high from the edge ending EXEC; 3 cycles/op minimum.
// Backpressure: result held stable while rsp_ready=0; no request accepted until the response handshake.
module logic_op_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*NREQ-1:0] valid_dbl;
    logic [2*NREQ-1:0] valid_rot_full;
    logic [NREQ-1:0]   valid_rot;
    logic              grant_found;
    logic [IDW-1:0]    grant_idx;
    int                grant_sum;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [WIDTH-1:0]  exec_result;
    logic [IDW-1:0]    next_ptr;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit is the winner.
    assign valid_dbl      = {req_valid, req_valid};
    assign valid_rot_full = valid_dbl >> rr_ptr;
    assign valid_rot      = valid_rot_full[NREQ-1:0];

    always_comb begin
        grant_found = 1'b0;
        grant_sum   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_found = 1'b1;
                grant_sum   = int'(rr_ptr) + k;
            end
        end
        if (grant_sum >= NREQ) grant_sum = grant_sum - NREQ;
        grant_idx = IDW'(grant_sum);
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        case (op_q)
            2'b00:   exec_result = ~a_q;
            2'b01:   exec_result = a_q & b_q;
            2'b10:   exec_result = a_q | b_q;
            default: exec_result = a_q ^ b_q;
        endcase
    end

    assign next_ptr  = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    assign req_ready = (rst_n && state == IDLE && grant_found) ? (NREQ'(1) << grant_idx) : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_q   <= sel_op;
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        rsp_id <= grant_idx;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= exec_result;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: scoreboard of expected results pushed on accept, popped on response.
module tb_logic_op_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic [15:0]           op_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] exp_data_q[$];
    logic [1:0] exp_id_q[$];

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = v;
        req_op[2*i +: 2] = op;
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
    endtask

    // Called at the negedge: whatever handshake is visible now happens at the next posedge.
    task automatic sb_capture(output int gid);
        gid = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                gid = i;
                exp_data_q.push_back(model(req_op[2*i +: 2], req_a[8*i +: 8], req_b[8*i +: 8]));
                exp_id_q.push_back(2'(i));
            end
        end
    endtask

    // Drives one transaction to completion and returns the observed response; drops valids afterwards.
    task automatic run_one(output logic [7:0] d, output logic [1:0] id, output int lat, output bit ok);
        int g;
        int acc;
        acc = 0; ok = 1'b0; d = '0; id = '0; lat = -1;
        for (int t = 0; t < 12 && !ok; t++) begin
            @(negedge clk);
            sb_capture(g);
            if (g >= 0) acc = cyc;
            if (rsp_valid && rsp_ready) begin
                d = rsp_data; id = rsp_id; lat = cyc - acc; ok = 1'b1;
            end
            @(posedge clk); #1;
            if (g >= 0) req_valid[g] = 1'b0;
            if (ok) req_valid = '0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d, ed;
        logic [1:0] id, ei;
        int lat;
        bit ok;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'b11, 8'(i * 17), 8'hF0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_ready got=%b want=0001", req_ready); end
        run_one(d, id, lat, ok);
        checks++;
        if (!ok || exp_data_q.size() == 0) begin
            failures++; $display("FAIL reset_first_rsp timeout got=none want=response");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            if (d !== ed || id !== ei || id !== 2'd0) begin
                failures++; $display("FAIL reset_first_rsp got=%h/id%0d want=%h/id0", d, id, ed);
            end
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] table_v [4] = '{8'h5A, 8'h24, 8'hBD, 8'h99};
        logic [7:0] d, ed;
        logic [1:0] id, ei;
        int lat;
        bit ok;
        rsp_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            set_req(2, 1'b1, 2'(op), 8'hA5, 8'h3C);
            run_one(d, id, lat, ok);
            if (!ok || exp_data_q.size() == 0) begin
                checks++; failures++; $display("FAIL op%0d timeout got=none want=response", op);
            end else begin
                ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
                checks++; if (d !== ed || d !== table_v[op]) begin failures++; $display("FAIL op%0d_data got=%h want=%h", op, d, table_v[op]); end
                checks++; if (id !== ei || id !== 2'd2) begin failures++; $display("FAIL op%0d_id got=%0d want=2", op, id); end
                checks++; if (lat != 2) begin failures++; $display("FAIL op%0d_latency got=%0d want=2", op, lat); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ed;
        logic [1:0] ei;
        int g, nresp, last_acc;
        bit gap_checked;
        nresp = 0; last_acc = -1; gap_checked = 1'b0;
        rst_n = 1'b0; #2; rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'(i), 8'(8'h30 + i), 8'h0F);
        for (int t = 0; t < 60 && nresp < 6; t++) begin
            @(negedge clk);
            sb_capture(g);
            if (g >= 0) begin
                if (last_acc >= 0 && !gap_checked) begin
                    checks++; if (cyc - last_acc != 3) begin failures++; $display("FAIL rr_accept_gap got=%0d want=3", cyc - last_acc); end
                    gap_checked = 1'b1;
                end
                last_acc = cyc;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++; failures++; $display("FAIL rr_sb_empty got=rsp want=none");
                end else begin
                    ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
                    checks++; if (rsp_data !== ed) begin failures++; $display("FAIL rr_data%0d got=%h want=%h", nresp, rsp_data, ed); end
                    checks++; if (rsp_id !== 2'(nresp % 4) || rsp_id !== ei) begin failures++; $display("FAIL rr_order%0d got=%0d want=%0d", nresp, rsp_id, nresp % 4); end
                end
                nresp++;
            end
            @(posedge clk); #1;
            if (nresp == 6) req_valid = '0;
        end
        if (nresp < 6) begin checks++; failures++; $display("FAIL rr_timeout got=%0d want=6", nresp); end
        @(negedge clk);
        checks++; if (op_count !== 16'd6) begin failures++; $display("FAIL rr_op_count got=%0d want=6", op_count); end
        checks++; if (exp_data_q.size() != 0) begin failures++; $display("FAIL rr_sb_leftover got=%0d want=0", exp_data_q.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] d0, d, ed;
        logic [1:0] i0, id, ei;
        int g, h, lat;
        bit ok, seen;
        seen = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 2'b10, 8'h0F, 8'hF0);
        set_req(3, 1'b1, 2'b01, 8'hCC, 8'hAA);
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            sb_capture(g);
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (g >= 0) req_valid[g] = 1'b0;
            end
        end
        if (!seen) begin checks++; failures++; $display("FAIL bp_timeout got=none want=rsp_valid"); end
        d0 = rsp_data; i0 = rsp_id;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++;
            if (rsp_data !== d0 || rsp_id !== i0 || req_ready !== 4'b0000 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d got=data%h id%0d rdy%b busy%b vld%b want=data%h id%0d rdy0000 busy1 vld1",
                         t, rsp_data, rsp_id, req_ready, busy, rsp_valid, d0, i0);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        if (exp_data_q.size() == 0) begin
            checks++; failures++; $display("FAIL bp_sb_empty got=rsp want=none");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            checks++; if (rsp_data !== ed || rsp_data !== 8'h88) begin failures++; $display("FAIL bp_data got=%h want=88", rsp_data); end
            checks++; if (rsp_id !== ei || rsp_id !== 2'd3) begin failures++; $display("FAIL bp_id got=%0d want=3", rsp_id); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        sb_capture(g);
        checks++; if (g != 0 || cyc - h != 1) begin failures++; $display("FAIL bp_next_accept got=req%0d@+%0d want=req0@+1", g, cyc - h); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        run_one(d, id, lat, ok);
        if (!ok || exp_data_q.size() == 0) begin
            checks++; failures++; $display("FAIL bp_second timeout got=none want=response");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            checks++; if (d !== ed || id !== ei || d !== 8'hFF) begin failures++; $display("FAIL bp_second got=%h/id%0d want=%h/id%0d", d, id, ed, ei); end
        end
    endtask

    task automatic test_skip_wrap();
        logic [7:0] d, ed;
        logic [1:0] id, ei;
        int lat;
        bit ok;
        rsp_ready = 1'b1;
        // requester 2 alone moves the pointer to 3
        set_req(2, 1'b1, 2'b11, 8'h55, 8'h0F);
        run_one(d, id, lat, ok);
        if (!ok || exp_data_q.size() == 0) begin
            checks++; failures++; $display("FAIL skip_setup timeout got=none want=response");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            checks++; if (d !== ed || id !== ei) begin failures++; $display("FAIL skip_setup got=%h/id%0d want=%h/id%0d", d, id, ed, ei); end
        end
        set_req(1, 1'b1, 2'b00, 8'h81, 8'h00);
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL skip_ready got=%b want=0010", req_ready); end
        run_one(d, id, lat, ok);
        if (!ok || exp_data_q.size() == 0) begin
            checks++; failures++; $display("FAIL skip_grant timeout got=none want=response");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            checks++; if (d !== ed || d !== 8'h7E || id !== 2'd1) begin failures++; $display("FAIL skip_grant got=%h/id%0d want=7e/id1", d, id); end
        end
        for (int i = 1; i < NREQ; i++) set_req(i, 1'b1, 2'b01, 8'hFF, 8'h3C);
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL wrap_next_ptr got=%b want=0100", req_ready); end
        run_one(d, id, lat, ok);
        if (!ok || exp_data_q.size() == 0) begin
            checks++; failures++; $display("FAIL wrap_rsp timeout got=none want=response");
        end else begin
            ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
            checks++; if (d !== ed || id !== 2'd2 || d !== 8'h3C) begin failures++; $display("FAIL wrap_rsp got=%h/id%0d want=3c/id2", d, id); end
        end
    endtask

    task automatic test_reset_mid_resp();
        int g;
        bit seen;
        seen = 1'b0;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 2'b10, 8'h12, 8'h40);
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            sb_capture(g);
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (g >= 0) req_valid[g] = 1'b0;
            end
        end
        checks++; if (!seen) begin failures++; $display("FAIL midrst_timeout got=none want=rsp_valid"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || busy !== 1'b0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=vld%b data%h id%0d busy%b cnt%0d want=vld0 data00 id0 busy0 cnt0",
                     rsp_valid, rsp_data, rsp_id, busy, op_count);
        end
        exp_data_q.delete();
        exp_id_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin failures++; $display("FAIL midrst_no_rsp got=vld%b cnt%0d want=vld0 cnt0", rsp_valid, op_count); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_opcodes();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
